lfsr_descrambler: RTL

Receive-side partner of the 32-bit scrambling shift register. It takes the serial bitstream produced by the scrambler, with feedback taps at bits 31, 29, 25 and 24 and the input bit XORed into the feedback, and runs it through a self-synchronising descrambler to recover the injected input bits. A lock state machine qualifies the recovered stream against a known idle value. Once locked, the block assembles recovered bits into bytes and counts bit errors. It sits between the input pin sampler and the downstream byte/LED logic.

---
 rtl/lfsr_pkg.sv | 25 ++
 rtl/lfsr_tap_xor.sv | 11 +
 rtl/lfsr_descrambler.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// Polynomial definition and lock-state encoding shared by the scrambler and descrambler.
package lfsr_pkg;

    localparam int unsigned LFSR_LEN = 32;
    localparam int unsigned TAP_A    = 31;
    localparam int unsigned TAP_B    = 29;
    localparam int unsigned TAP_C    = 25;
    localparam int unsigned TAP_D    = 24;

    localparam logic [LFSR_LEN-1:0] TAP_MASK = (LFSR_LEN'(1) << TAP_A) | (LFSR_LEN'(1) << TAP_B)
                                             | (LFSR_LEN'(1) << TAP_C) | (LFSR_LEN'(1) << TAP_D);

    // Fill, match and window counters all span one register length.
    localparam int unsigned          CNT_W   = 5;
    localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(LFSR_LEN - 1);
    localparam int unsigned          WERR_W  = 6;
    localparam int unsigned          BCNT_W  = 3;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } lock_state_e;

endpackage

// File: rtl/lfsr_tap_xor.sv
// Combinational feedback of the 32-bit scrambling polynomial (taps 31, 29, 25, 24).
module lfsr_tap_xor
    import lfsr_pkg::*;
(
    input  logic [LFSR_LEN-1:0] state_i,
    output logic                fb_c_o
);

    assign fb_c_o = ^(state_i & TAP_MASK);

endmodule

// File: rtl/lfsr_descrambler.sv
// Self-synchronising descrambler with lock qualification, byte assembly and error counting.
module lfsr_descrambler
    import lfsr_pkg::*;
#(
    parameter logic        EXPECT   = 1'b1,
    parameter int unsigned LOSS_THR = 8,
    parameter int unsigned ERRW     = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            bit_in,
    input  logic            bit_en,
    output logic [7:0]      data,
    output logic            data_valid,
    output logic            locked,
    output logic [ERRW-1:0] err_count
);

    logic [LFSR_LEN-1:0] r_q, r_d;
    lock_state_e         state_q, state_d;
    logic [CNT_W-1:0]    fill_cnt_q, fill_cnt_d;
    logic [CNT_W-1:0]    match_cnt_q, match_cnt_d;
    logic [CNT_W-1:0]    win_cnt_q, win_cnt_d;
    logic [WERR_W-1:0]   win_err_q, win_err_d;
    logic [BCNT_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [6:0]          byte_sr_q, byte_sr_d;
    logic [7:0]          data_q, data_d;
    logic                dv_q, dv_d;
    logic                locked_q, locked_d;
    logic [ERRW-1:0]     err_q, err_d;

    logic fb_c;
    logic rec_c;
    logic miss_c;

    lfsr_tap_xor u_tap_xor (
        .state_i (r_q),
        .fb_c_o  (fb_c)
    );

    assign rec_c  = bit_in ^ fb_c;
    assign miss_c = (rec_c != EXPECT);

    // Next-state logic; everything advances only on a bit strobe.
    always_comb begin
        r_d         = r_q;
        state_d     = state_q;
        fill_cnt_d  = fill_cnt_q;
        match_cnt_d = match_cnt_q;
        win_cnt_d   = win_cnt_q;
        win_err_d   = win_err_q;
        byte_cnt_d  = byte_cnt_q;
        byte_sr_d   = byte_sr_q;
        data_d      = data_q;
        dv_d        = 1'b0;
        err_d       = err_q;

        if (bit_en) begin
            r_d = {r_q[LFSR_LEN-2:0], bit_in};
            unique case (state_q)
                FILL: begin
                    fill_cnt_d = fill_cnt_q + CNT_W'(1);
                    if (fill_cnt_q == CNT_MAX) begin
                        state_d     = CHECK;
                        match_cnt_d = '0;
                    end
                end
                CHECK: begin
                    if (!miss_c) begin
                        match_cnt_d = match_cnt_q + CNT_W'(1);
                        if (match_cnt_q == CNT_MAX) begin
                            state_d    = LOCKED;
                            win_cnt_d  = '0;
                            win_err_d  = '0;
                            byte_cnt_d = '0;
                        end
                    end else begin
                        match_cnt_d = '0;
                    end
                end
                LOCKED: begin
                    win_cnt_d  = win_cnt_q + CNT_W'(1);
                    byte_cnt_d = byte_cnt_q + BCNT_W'(1);
                    byte_sr_d  = {byte_sr_q[5:0], rec_c};
                    if (miss_c) begin
                        win_err_d = win_err_q + WERR_W'(1);
                        if (err_q != '1) begin
                            err_d = err_q + ERRW'(1);
                        end
                    end
                    if (miss_c && (win_err_q + WERR_W'(1) == WERR_W'(LOSS_THR))) begin
                        // Partial byte is abandoned; r keeps shifting so refill resyncs.
                        state_d    = FILL;
                        fill_cnt_d = '0;
                    end else begin
                        if (win_cnt_q == CNT_MAX) begin
                            win_err_d = '0;
                        end
                        if (byte_cnt_q == BCNT_W'(7)) begin
                            data_d = {byte_sr_q, rec_c};
                            dv_d   = 1'b1;
                        end
                    end
                end
                default: state_d = FILL;
            endcase
        end

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q         <= '0;
            state_q     <= FILL;
            fill_cnt_q  <= '0;
            match_cnt_q <= '0;
            win_cnt_q   <= '0;
            win_err_q   <= '0;
            byte_cnt_q  <= '0;
            byte_sr_q   <= '0;
            data_q      <= '0;
            dv_q        <= 1'b0;
            locked_q    <= 1'b0;
            err_q       <= '0;
        end else begin
            r_q         <= r_d;
            state_q     <= state_d;
            fill_cnt_q  <= fill_cnt_d;
            match_cnt_q <= match_cnt_d;
            win_cnt_q   <= win_cnt_d;
            win_err_q   <= win_err_d;
            byte_cnt_q  <= byte_cnt_d;
            byte_sr_q   <= byte_sr_d;
            data_q      <= data_d;
            dv_q        <= dv_d;
            locked_q    <= locked_d;
            err_q       <= err_d;
        end
    end

    assign data       = data_q;
    assign data_valid = dv_q;
    assign locked     = locked_q;
    assign err_count  = err_q;

endmodule
